dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 64, number of BUSY cycles without mem_ack before a timeout error is declared (range 2..255).
REQ-002 SHALL provide port: clk  input  1  single core clock; all logic SHALL be clocked on its rising edge only.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port: memoryRead  input  1  core load request.
REQ-005 SHALL provide port: writeFlag  input  1  core store request.
REQ-006 SHALL provide port: addressIn  input  32  core byte address.
REQ-007 SHALL provide port: dataOut  input  32  core store data.
REQ-008 SHALL provide port: memoryDataIn  output  32  load data returned to the core.
REQ-009 SHALL provide port: stall  output  1  core SHALL hold PC and request while high.
REQ-010 SHALL provide port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port: err_bits  output  2  sticky error code (00 none, 01 misaligned, 10 timeout, 11 read+write conflict).
REQ-012 SHALL provide port: mem_req, mem_we  output  1 each  memory-side request and write-enable.
REQ-013 SHALL provide port: mem_addr, mem_wdata  output  32 each  memory-side address and store data.
REQ-014 SHALL provide port: mem_rdata  input  32, mem_ack  input  1  memory-side read data and acknowledge.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 In IDLE with exactly one of memoryRead/writeFlag high and addressIn[1:0]==0, SHALL register address, data and direction, and go to BUSY.
REQ-017 stall SHALL be combinational: high in IDLE while a valid request is present, and high throughout BUSY; low in DONE.
REQ-018 In BUSY, mem_req SHALL be high, with mem_addr/mem_wdata/mem_we driven from the registered values and held stable until mem_ack.
REQ-019 mem_ack SHALL be honoured only while mem_req is high; on ack the FSM SHALL go to DONE and a load SHALL capture mem_rdata into memoryDataIn.
REQ-020 Minimum latency: request seen in cycle 0, mem_req in cycle 1, ack in cycle 1, done high in cycle 2; each extra wait cycle adds one.
REQ-021 In DONE, done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE; requests during DONE SHALL be ignored.
REQ-022 memoryDataIn SHALL hold its value until the next completed load; stores and errors SHALL NOT change it.
REQ-023 A misaligned request (addressIn[1:0]!=0) SHALL issue no memory access, set err_bits=01, and go directly to DONE.
REQ-024 memoryRead and writeFlag high together SHALL issue no access, set err_bits=11, and go to DONE.
REQ-025 err_bits SHALL latch the first error and hold it until reset; later errors SHALL NOT overwrite it.
REQ-026 mem_ack outside BUSY SHALL be ignored with no state change.

Reset
REQ-027 When rst is low at a clock edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, memoryDataIn=0, done=0, err_bits=00, timeout count=0.
REQ-028 Reset asserted mid-BUSY SHALL drop mem_req at that edge with no done pulse; a late mem_ack SHALL be ignored.

Configuration
REQ-029 With macro DMEM_BRIDGE_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; when it reaches TIMEOUT_CYCLES without ack, mem_req SHALL drop, err_bits SHALL be set to 10 (if clear), and the FSM SHALL go to DONE with memoryDataIn unchanged.
REQ-030 Without DMEM_BRIDGE_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait indefinitely, and code 10 SHALL never occur.

Structure
REQ-031 Package dmem_bridge_pkg SHALL hold the FSM state encoding and the err_bits code constants (ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_CONFLICT).
REQ-032 The timeout counter SHALL be one sub-module, dmem_timeout_ctr (inputs clear/enable, output expired), instantiated only under DMEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-033 Load from 0x0000_0010 with mem_ack in the same cycle as mem_req and mem_rdata=0xDEAD_BEEF -> done in cycle 2, memoryDataIn=0xDEAD_BEEF, err_bits=00.
REQ-034 Store of 0x1234_5678 to 0x20 with 3 wait cycles -> mem_we=1, mem_addr=0x20, mem_wdata stable for 4 cycles, done in cycle 5, memoryDataIn unchanged.
REQ-035 Load from 0x0000_0013 -> mem_req never high, done in cycle 1, err_bits=01; a following conflict (both requests high) leaves err_bits=01.
REQ-036 With the macro defined, TIMEOUT_CYCLES=8 and no ack -> mem_req high for 8 cycles then low, err_bits=10, one done pulse.
REQ-037 rst driven low in the 2nd BUSY cycle, then mem_ack pulsed -> mem_req=0 and state IDLE after the edge, no done pulse, all outputs at reset values.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, error codes
// and the sticky error merge helper.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  // Wide enough for the largest legal timeout (255 cycles).
  localparam int unsigned TIMEOUT_CTR_W = 8;

  // First error wins: a recorded code is never replaced until reset.
  function automatic logic [1:0] err_merge(input logic [1:0] cur, input logic [1:0] nxt);
    return (cur == ERR_NONE) ? nxt : cur;
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts consecutive enabled cycles and flags the cycle in which the
// LIMIT-th one is reached. Synchronous active-low reset.
module dmem_timeout_ctr
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_CTR_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of earlier enabled cycles, so LIMIT-1 marks the LIMIT-th.
  assign expired = enable && (r_count == TIMEOUT_CTR_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Core-to-memory bridge: one outstanding load/store with stall/done handshake
// and sticky error reporting. Optional BUSY timeout under DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryRead,
  input  logic        writeFlag,
  input  logic [31:0] addressIn,
  input  logic [31:0] dataOut,
  output logic [31:0] memoryDataIn,
  output logic        stall,
  output logic        done,
  output logic [1:0]  err_bits,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dmem_bridge: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t      r_state;
  logic        r_done;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;

  logic w_any_req;
  logic w_conflict;
  logic w_misalign;
  logic w_ack;
  logic w_busy;
  logic w_expired;

  assign w_any_req  = memoryRead | writeFlag;
  assign w_conflict = memoryRead & writeFlag;
  assign w_misalign = (addressIn[1:0] != 2'b00);
  assign w_busy     = (r_state == BUSY);
  assign w_ack      = mem_ack & r_mem_req;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  dmem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_busy),
    .enable  (w_busy),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            // Conflict outranks misalignment: neither issues a memory access.
            if (w_conflict) begin
              r_err   <= err_merge(r_err, ERR_CONFLICT);
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_misalign) begin
              r_err   <= err_merge(r_err, ERR_MISALIGN);
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= writeFlag;
              r_mem_addr  <= addressIn;
              r_mem_wdata <= dataOut;
              r_state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (w_ack) begin
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (w_expired) begin
            r_err     <= err_merge(r_err, ERR_TIMEOUT);
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the core freezes in the same cycle it presents a request.
  assign stall = w_busy || ((r_state == IDLE) && w_any_req);

  assign memoryDataIn = r_rdata;
  assign done         = r_done;
  assign err_bits     = r_err;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized scoreboard bench for dmem_bridge: a transaction-level model predicts
// completion cycle, load data and sticky error; monitor and memory responder check.
module tb_dmem_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memoryRead = 1'b0;
  logic        writeFlag = 1'b0;
  logic [31:0] addressIn = '0;
  logic [31:0] dataOut = '0;
  logic [31:0] memoryDataIn;
  logic        stall;
  logic        done;
  logic [1:0]  err_bits;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .memoryRead   (memoryRead),
    .writeFlag    (writeFlag),
    .addressIn    (addressIn),
    .dataOut      (dataOut),
    .memoryDataIn (memoryDataIn),
    .stall        (stall),
    .done         (done),
    .err_bits     (err_bits),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } acc_t;

  exp_t sb_q[$];
  acc_t acc_q[$];

  // Reference model state: word memory, last loaded value, sticky error.
  logic [31:0] ref_mem[int];
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_err = 2'b00;

  // Memory device owned by the responder.
  logic [31:0] dev_mem[int];
  int          ack_wait = 0;
  logic        late_ack = 1'b0;

  function automatic logic [31:0] seed_word(input int idx);
    return 32'hDEADBEEF ^ ((32'(idx) - 32'd4) * 32'h9E3779B9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("memoryDataIn", memoryDataIn, e.rdata);
        chk("err_bits", {30'd0, err_bits}, {30'd0, e.err});
        chk("stall_in_done", {31'd0, stall}, 32'd0);
      end
    end
  end

  // Memory responder: checks request fields and their stability, acks after ack_wait cycles.
  int   busy_cnt = 0;
  acc_t cur;
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      chk("stall_busy", {31'd0, stall}, 32'd1);
      if (busy_cnt == 0) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: got mem_req=1 addr=0x%08h expected no access", mem_addr);
          cur = '{mem_we, mem_addr, mem_wdata, 1'b0};
        end else begin
          cur = acc_q.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
          chk("mem_addr", mem_addr, cur.addr);
          if (cur.chk_wdata) chk("mem_wdata", mem_wdata, cur.wdata);
        end
      end else begin
        chk("mem_addr_hold", mem_addr, cur.addr);
        chk("mem_we_hold", {31'd0, mem_we}, {31'd0, cur.we});
        if (cur.chk_wdata) chk("mem_wdata_hold", mem_wdata, cur.wdata);
      end
      if (busy_cnt == ack_wait) begin
        int idx;
        idx = int'(mem_addr[5:2]);
        mem_ack = 1'b1;
        mem_rdata = dev_mem.exists(idx) ? dev_mem[idx] : seed_word(idx);
        if (mem_we) dev_mem[idx] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      mem_ack = late_ack | ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_memoryDataIn"}, memoryDataIn, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err_bits"}, {30'd0, err_bits}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    memoryRead = 1'b0;
    writeFlag = 1'b0;
    late_ack = 1'b0;
    @(negedge clk);
    check_reset_state(tag);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    acc_q.delete();
    m_rdata = '0;
    m_err = 2'b00;
  endtask

  int txn_n = 0;

  // One core request: predict the outcome, hold the request until done, then release.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int waits, input bit garbage);
    exp_t e;
    int   lat;
    bit   got;
    bit   timed_out;
    int   idx;
    @(negedge clk);
    memoryRead = rd;
    writeFlag = wr;
    addressIn = a;
    dataOut = d;
    ack_wait = waits;
    idx = int'(a[5:2]);
    timed_out = 1'b0;
    if (rd && wr) begin
      if (m_err == 2'b00) m_err = 2'b11;
      lat = 1;
    end else if (a[1:0] != 2'b00) begin
      if (m_err == 2'b00) m_err = 2'b01;
      lat = 1;
    end else begin
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      timed_out = (waits >= TO);
`endif
      acc_q.push_back('{wr, a, d, wr});
      if (timed_out) begin
        lat = 1 + TO;
        if (m_err == 2'b00) m_err = 2'b10;
      end else begin
        lat = 2 + waits;
        if (wr) ref_mem[idx] = d;
        else m_rdata = ref_mem.exists(idx) ? ref_mem[idx] : seed_word(idx);
      end
    end
    e.done_cyc = cyc + lat;
    e.rdata = m_rdata;
    e.err = m_err;
    sb_q.push_back(e);
    #1;
    chk("stall_on_request", {31'd0, stall}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done within 300 cycles expected done for txn %0d", txn_n);
      sb_q.delete();
      acc_q.delete();
    end
    $display("txn %0d rd=%0b wr=%0b addr=0x%08h data=0x%08h waits=%0d -> rdata=0x%08h err=%0b",
             txn_n, rd, wr, a, d, waits, memoryDataIn, err_bits);
    txn_n++;
    if (garbage) begin
      memoryRead = 1'($urandom);
      writeFlag = 1'($urandom);
      addressIn = 32'($urandom_range(0, 63));
      dataOut = $urandom;
    end else begin
      memoryRead = 1'b0;
      writeFlag = 1'b0;
    end
    @(negedge clk);
    memoryRead = 1'b0;
    writeFlag = 1'b0;
    #1;
    chk("stall_idle", {31'd0, stall}, 32'd0);
  endtask

  task automatic random_phase(input int n, input bit with_errors);
    for (int k = 0; k < n; k++) begin
      logic        rd, wr;
      logic [31:0] a;
      int          sel;
      a = 32'($urandom_range(0, 15)) << 2;
      sel = with_errors ? $urandom_range(0, 11) : $urandom_range(2, 11);
      rd = 1'b0;
      wr = 1'b0;
      if (sel == 0) begin
        rd = 1'b1;
        wr = 1'b1;
      end else begin
        if (sel == 1) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) wr = 1'b1;
        else rd = 1'b1;
      end
      issue(rd, wr, a, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    do_reset("reset");

    // Load with zero wait state.
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
    chk("load_deadbeef", memoryDataIn, 32'hDEAD_BEEF);
    chk("load_err_none", {30'd0, err_bits}, 32'd0);

    // Store with three wait states leaves load data untouched.
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 1'b0);
    chk("store_keeps_rdata", memoryDataIn, 32'hDEAD_BEEF);
    chk("store_reached_mem", dev_mem.exists(8) ? dev_mem[8] : 32'h0, 32'h1234_5678);

    random_phase(40, 1'b0);

    // Reset in the second BUSY cycle, then a late acknowledge.
    @(negedge clk);
    memoryRead = 1'b1;
    writeFlag = 1'b0;
    addressIn = 32'h0000_0024;
    ack_wait = 1000;
    acc_q.push_back('{1'b0, 32'h0000_0024, 32'h0, 1'b0});
    @(negedge clk);
    chk("rst_busy1_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    chk("rst_busy2_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    memoryRead = 1'b0;
    @(negedge clk);
    check_reset_state("rst_midbusy");
    rst = 1'b1;
    late_ack = 1'b1;
    m_rdata = '0;
    m_err = 2'b00;
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    late_ack = 1'b0;
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    chk("late_ack_rdata", memoryDataIn, 32'd0);
    @(negedge clk);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    issue(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1000, 1'b0);
    chk("timeout_err", {30'd0, err_bits}, 32'd2);
    chk("timeout_req_low", {31'd0, mem_req}, 32'd0);
    chk("timeout_rdata", memoryDataIn, 32'd0);
    do_reset("reset2");
`endif

    // Misaligned load, then a conflict that must not overwrite the first error.
    issue(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 1'b0);
    chk("misalign_err", {30'd0, err_bits}, 32'd1);
    issue(1'b1, 1'b1, 32'h0000_0030, 32'h0, 0, 1'b0);
    chk("conflict_keeps_err", {30'd0, err_bits}, 32'd1);

    random_phase(40, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("accesses_drained", 32'(acc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
